can_rx_sequencer: RTL

Frame-level controller for the CAN receive path. Qualifies bus idle, arms the packet-capture state machine on start-of-frame, and holds its reset outside frames. Enforces a frame timeout, filters frames on the CRC result, and queues good frames in a 2-entry buffer for the SPI readout with a valid/ack handshake. Replaces the ad-hoc start-detect register in the top level and runs entirely on the 12 MHz system clock.

---
 rtl/can_rx_sequencer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/can_rx_sequencer.sv
// CAN receive frame sequencer: idle qualification, capture arming, frame timeout,
// CRC filtering and a 2-entry frame buffer drained over a valid/ack handshake.
module can_rx_sequencer #(
  parameter int CLK_MAX   = 96,
  parameter int IDLE_BITS = 11,
  parameter int MAX_BITS  = 160,
  parameter int FRAME_W   = 135
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx,
  input  logic               cap_done,
  input  logic               cap_crc_ok,
  input  logic [FRAME_W-1:0] cap_frame,
  output logic               cap_rst,
  output logic [FRAME_W-1:0] frame_data,
  output logic               frame_valid,
  input  logic               frame_ack,
  input  logic               ovf_clr,
  output logic               overflow,
  output logic               crc_err,
  output logic               timeout,
  output logic [7:0]         frame_cnt,
  output logic               busy
);

  localparam int IDLE_LIM = IDLE_BITS * CLK_MAX;
  localparam int BIT_LIM  = MAX_BITS * CLK_MAX;
  localparam int IDLE_W   = $clog2(IDLE_LIM);
  localparam int BIT_W    = $clog2(BIT_LIM);
  localparam logic [IDLE_W-1:0] IDLE_END = IDLE_W'(IDLE_LIM - 1);
  localparam logic [BIT_W-1:0]  BIT_END  = BIT_W'(BIT_LIM - 1);

  // state     | meaning
  // IDLE_WAIT | capture held in reset, counting recessive clocks
  // ARMED     | bus qualified idle, waiting for SOF
  // RECV      | capture running, frame timer active
  // STORE     | one cycle: CRC filter and buffer push
  localparam logic [1:0] S_IDLE_WAIT = 2'd0;
  localparam logic [1:0] S_ARMED     = 2'd1;
  localparam logic [1:0] S_RECV      = 2'd2;
  localparam logic [1:0] S_STORE     = 2'd3;

  logic               rx_m, rx_s;
  logic               cd_m, cd_s, cd_q;
  logic [1:0]         state, state_n;
  logic [IDLE_W-1:0]  idle_cnt, idle_cnt_n;
  logic [BIT_W-1:0]   bit_cnt, bit_cnt_n;
  logic [FRAME_W-1:0] hold_frame;
  logic               hold_crc;

  logic [FRAME_W-1:0] mem [2];
  logic [FRAME_W-1:0] mem_n [2];
  logic               wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [1:0]         count, count_n;
  logic [FRAME_W-1:0] head_n;

  logic done_edge, pop, in_store, push, drop_ovf, to_hit;

  assign done_edge = cd_s & ~cd_q;
  assign pop       = frame_valid & frame_ack;
  assign in_store  = (state == S_STORE);
  assign push      = in_store & hold_crc & ((count != 2'd2) | pop);
  assign drop_ovf  = in_store & hold_crc & (count == 2'd2) & ~pop;
  assign to_hit    = (state == S_RECV) & ~done_edge & (bit_cnt == BIT_END);

  always_comb begin
    state_n    = state;
    idle_cnt_n = '0;
    bit_cnt_n  = bit_cnt;
    case (state)
      S_IDLE_WAIT: begin
        if (rx_s) begin
          if (idle_cnt == IDLE_END) state_n = S_ARMED;
          else                      idle_cnt_n = idle_cnt + 1'b1;
        end
      end
      S_ARMED: begin
        if (!rx_s) begin
          state_n   = S_RECV;
          bit_cnt_n = '0;
        end
      end
      S_RECV: begin
        // a done edge on the last timer cycle still takes the frame
        if (done_edge)                 state_n = S_STORE;
        else if (bit_cnt == BIT_END)   state_n = S_IDLE_WAIT;
        else                           bit_cnt_n = bit_cnt + 1'b1;
      end
      S_STORE: state_n = S_IDLE_WAIT;
      default: state_n = S_IDLE_WAIT;
    endcase
  end

  always_comb begin
    mem_n[0] = mem[0];
    mem_n[1] = mem[1];
    if (push) mem_n[wr_ptr] = hold_frame;
    wr_ptr_n = wr_ptr ^ push;
    rd_ptr_n = rd_ptr ^ pop;
    count_n  = count + 2'(push) - 2'(pop);
    head_n   = (count_n != 2'd0) ? mem_n[rd_ptr_n] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m        <= 1'b1;
      rx_s        <= 1'b1;
      cd_m        <= 1'b0;
      cd_s        <= 1'b0;
      cd_q        <= 1'b0;
      state       <= S_IDLE_WAIT;
      idle_cnt    <= '0;
      bit_cnt     <= '0;
      hold_frame  <= '0;
      hold_crc    <= 1'b0;
      mem[0]      <= '0;
      mem[1]      <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      cap_rst     <= 1'b1;
      busy        <= 1'b0;
      crc_err     <= 1'b0;
      timeout     <= 1'b0;
      overflow    <= 1'b0;
      frame_cnt   <= 8'd0;
    end else begin
      rx_m     <= rx;
      rx_s     <= rx_m;
      cd_m     <= cap_done;
      cd_s     <= cd_m;
      cd_q     <= cd_s;
      state    <= state_n;
      idle_cnt <= idle_cnt_n;
      bit_cnt  <= bit_cnt_n;
      if ((state == S_RECV) && done_edge) begin
        hold_frame <= cap_frame;
        hold_crc   <= cap_crc_ok;
      end
      mem[0]      <= mem_n[0];
      mem[1]      <= mem_n[1];
      wr_ptr      <= wr_ptr_n;
      rd_ptr      <= rd_ptr_n;
      count       <= count_n;
      frame_data  <= head_n;
      frame_valid <= (count_n != 2'd0);
      cap_rst     <= (state_n != S_RECV);
      busy        <= (state_n == S_RECV) || (state_n == S_STORE);
      crc_err     <= in_store & ~hold_crc;
      timeout     <= to_hit;
      if (push) frame_cnt <= frame_cnt + 8'd1;
      // a drop in the same cycle as a clear leaves the flag set
      overflow    <= drop_ovf | (overflow & ~ovf_clr);
    end
  end

endmodule
